// File: rtl/fpu_pkg.sv
// Shared encodings for the FPU issue stage: opcodes, OP-FP funct5 selectors
// and the bubble word sent to the FPU when nothing issues.
package fpu_pkg;

   localparam logic [6:0] OPC_FLW  = 7'b0000111;
   localparam logic [6:0] OPC_FSW  = 7'b0100111;
   localparam logic [6:0] OPC_OPFP = 7'b1010011;

   localparam logic [4:0] F5_ADD    = 5'b00000;
   localparam logic [4:0] F5_SUB    = 5'b00001;
   localparam logic [4:0] F5_MUL    = 5'b00010;
   localparam logic [4:0] F5_CVT_WS = 5'b11000;
   localparam logic [4:0] F5_CVT_SW = 5'b11010;

   localparam logic [31:0] FPU_NOP = 32'h0;

endpackage

// File: rtl/fpu_issue_decode.sv
// Float-register usage decode: which of rs1/rs2 are float reads and
// whether rd is a float write. Unknown encodings use no float registers.
module fpu_issue_decode
   import fpu_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [4:0] i_funct5,
   output logic       o_reads_rs1,
   output logic       o_reads_rs2,
   output logic       o_writes_rd
);

   always_comb begin
      o_reads_rs1 = 1'b0;
      o_reads_rs2 = 1'b0;
      o_writes_rd = 1'b0;
      case (i_opcode)
         OPC_FLW: o_writes_rd = 1'b1;
         OPC_FSW: o_reads_rs2 = 1'b1;
         OPC_OPFP: begin
            case (i_funct5)
               F5_ADD, F5_SUB, F5_MUL: begin
                  o_reads_rs1 = 1'b1;
                  o_reads_rs2 = 1'b1;
                  o_writes_rd = 1'b1;
               end
               F5_CVT_SW: o_writes_rd = 1'b1;
               F5_CVT_WS: o_reads_rs1 = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/fpu_issue.sv
// FPU issue/interlock stage: per-register countdown scoreboard stalls RAW
// hazards against the fixed-depth writeback. Statistics under FPU_ISSUE_STATS_EN.
module fpu_issue
   import fpu_pkg::*;
#(
   parameter int PIPE_DEPTH = 5,
   parameter int NREG       = 32,
   parameter int CNT_W      = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] in_inst,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] fpu_inst,
   output logic        fpu_busy,
   output logic [31:0] stall_cnt,
   output logic [31:0] issue_cnt
);

   logic [NREG-1:0][CNT_W-1:0] r_cnt;
   logic [NREG-1:0][CNT_W-1:0] w_cnt_nxt;
   logic [31:0]                r_fpu_inst;
   logic                       r_busy;
   logic                       w_rd_rs1, w_rd_rs2, w_wr_rd;
   logic                       w_hazard, w_fire;
   logic                       w_busy_nxt;
   logic [4:0]                 w_rs1, w_rs2, w_rd;

   assign w_rs1 = in_inst[19:15];
   assign w_rs2 = in_inst[24:20];
   assign w_rd  = in_inst[11:7];

   fpu_issue_decode u_decode (
      .i_opcode    (in_inst[6:0]),
      .i_funct5    (in_inst[31:27]),
      .o_reads_rs1 (w_rd_rs1),
      .o_reads_rs2 (w_rd_rs2),
      .o_writes_rd (w_wr_rd)
   );

   // Hazard looks at counters as registered, before this edge's update.
   assign w_hazard = (w_rd_rs1 && (r_cnt[w_rs1] != '0)) ||
                     (w_rd_rs2 && (r_cnt[w_rs2] != '0));
   assign in_ready = rstn & ~w_hazard;
   assign w_fire   = in_valid & in_ready;

   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_busy_nxt = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         if (w_fire && w_wr_rd && (w_rd == 5'(r)))
            w_cnt_nxt[r] = CNT_W'(PIPE_DEPTH);
         else if (r_cnt[r] != '0)
            w_cnt_nxt[r] = r_cnt[r] - 1'b1;
         w_busy_nxt = w_busy_nxt | (w_cnt_nxt[r] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cnt      <= '0;
         r_fpu_inst <= FPU_NOP;
         r_busy     <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_fpu_inst <= w_fire ? in_inst : FPU_NOP;
         r_busy     <= w_busy_nxt;
      end
   end

   assign fpu_inst = r_fpu_inst;
   assign fpu_busy = r_busy;

`ifdef FPU_ISSUE_STATS_EN
   logic [31:0] r_stall_cnt, r_issue_cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_stall_cnt <= '0;
         r_issue_cnt <= '0;
      end else begin
         if (in_valid && !in_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_fire)                r_issue_cnt <= r_issue_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign issue_cnt = r_issue_cnt;
`else
   assign stall_cnt = 32'h0;
   assign issue_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: cycle model of the register scoreboard,
// expected issue words queued per cycle and compared after each edge.
module tb_fpu_issue;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] in_inst = 32'h0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] fpu_inst;
   logic        fpu_busy;
   logic [31:0] stall_cnt;
   logic [31:0] issue_cnt;

   fpu_issue dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_inst   (in_inst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fpu_inst  (fpu_inst),
      .fpu_busy  (fpu_busy),
      .stall_cnt (stall_cnt),
      .issue_cnt (issue_cnt)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   int          mcnt[32];
   logic        m_fire;
   logic        m_wr;
   logic [4:0]  m_rd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] opfp(input logic [4:0] f5, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
      return {f5, 2'b00, rs2, rs1, 3'b000, rd, 7'b1010011};
   endfunction
   function automatic logic [31:0] flw(input logic [4:0] rd);
      return {12'h0, 5'd2, 3'b010, rd, 7'b0000111};
   endfunction
   function automatic logic [31:0] fsw(input logic [4:0] rs2, input logic [4:0] rs1);
      return {7'h0, rs2, rs1, 3'b010, 5'h0, 7'b0100111};
   endfunction

   // Reference decode, written from the instruction table.
   function automatic void mdec(input logic [31:0] w, output logic r1, output logic r2,
                                output logic wr);
      r1 = 0; r2 = 0; wr = 0;
      if (w[6:0] == 7'b0000111) wr = 1;
      else if (w[6:0] == 7'b0100111) r2 = 1;
      else if (w[6:0] == 7'b1010011) begin
         if (w[31:27] <= 5'd2) begin r1 = 1; r2 = 1; wr = 1; end
         else if (w[31:27] == 5'b11010) wr = 1;
         else if (w[31:27] == 5'b11000) r1 = 1;
      end
   endfunction

   // One cycle: drive, check ready at negedge, advance model, check issue after edge.
   task automatic step(input logic [31:0] w, input logic v, output logic acc);
      logic r1, r2, wr, rdy, busy;
      in_inst = w; in_valid = v;
      @(negedge clk);
      mdec(w, r1, r2, wr);
      rdy = !((r1 && mcnt[w[19:15]] != 0) || (r2 && mcnt[w[24:20]] != 0));
      chk("in_ready", {31'h0, in_ready}, {31'h0, rdy});
      acc = v && rdy;
      exp_q.push_back(acc ? w : 32'h0);
      @(posedge clk);
      busy = 0;
      for (int r = 0; r < 32; r++) begin
         if (mcnt[r] > 0) mcnt[r]--;
         if (acc && wr && w[11:7] == 5'(r)) mcnt[r] = 5;
         if (mcnt[r] != 0) busy = 1;
      end
      #1;
      chk("fpu_inst", fpu_inst, exp_q.pop_front());
      chk("fpu_busy", {31'h0, fpu_busy}, {31'h0, busy});
   endtask

   // Present w until accepted; returns stall cycles and bubbles seen.
   task automatic issue(input logic [31:0] w, output int stalls, output int bubbles);
      logic acc;
      stalls = 0; bubbles = 0;
      for (int i = 0; i < 20; i++) begin
         step(w, 1'b1, acc);
         if (fpu_inst == 32'h0) bubbles++;
         if (acc) break;
         stalls++;
      end
      if (stalls >= 20) chk("issue_timeout", 32'(stalls), 32'd0);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(32'h0, 1'b0, acc);
   endtask

   task automatic do_reset(input int cycles, input logic [31:0] w, input logic v);
      rstn = 1'b0; in_inst = w; in_valid = v;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk("rst_ready", {31'h0, in_ready}, 32'h0);
         @(posedge clk); #1;
         chk("rst_inst", fpu_inst, 32'h0);
         chk("rst_busy", {31'h0, fpu_busy}, 32'h0);
      end
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      rstn = 1'b1;
   endtask

   initial begin
      int st, bb, tail;
      logic acc;
      logic [31:0] fadd1, fsub1;
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      fadd1 = opfp(5'b00000, 5'd1, 5'd2, 5'd3);
      fsub1 = opfp(5'b00001, 5'd4, 5'd1, 5'd5);

      // 1: reset with a pending instruction, then it issues immediately
      do_reset(2, opfp(5'b00000, 5'd3, 5'd1, 5'd2), 1'b1);
      issue(opfp(5'b00000, 5'd3, 5'd1, 5'd2), st, bb);
      chk("t1_stall", 32'(st), 32'd0);
      idle(6);

      // 2: independent stream, busy tail length
      issue(opfp(5'b00000, 5'd1, 5'd2, 5'd3), st, bb); chk("t2_st0", 32'(st), 0);
      issue(opfp(5'b00010, 5'd4, 5'd5, 5'd6), st, bb); chk("t2_st1", 32'(st), 0);
      issue(flw(5'd7), st, bb);                        chk("t2_st2", 32'(st), 0);
      chk("t2_busy_issue", {31'h0, fpu_busy}, 32'd1);
      tail = 0;
      for (int i = 0; i < 10 && fpu_busy; i++) begin step(32'h0, 1'b0, acc); tail++; end
      chk("t2_busy_tail", 32'(tail), 32'd5);

      // 3 + 6: RAW on rs1 after a clean reset so the statistics start at zero
      idle(2);
      do_reset(1, 32'h0, 1'b0);
      issue(fadd1, st, bb);
      issue(fsub1, st, bb);
      chk("t3_stall", 32'(st), 32'd5);
      chk("t3_bubbles", 32'(bb), 32'd5);
`ifdef FPU_ISSUE_STATS_EN
      chk("t6_issue_cnt", issue_cnt, 32'd2);
      chk("t6_stall_cnt", stall_cnt, 32'd5);
`else
      chk("t6_issue_cnt", issue_cnt, 32'd0);
      chk("t6_stall_cnt", stall_cnt, 32'd0);
`endif
      idle(6);

      // 4: store and convert dependencies, fsw rs1 is not a float read
      issue(flw(5'd8), st, bb);
      issue(fsw(5'd8, 5'd0), st, bb);
      chk("t4_fsw_stall", 32'(st), 32'd5);
      issue(opfp(5'b11010, 5'd9, 5'd1, 5'd0), st, bb);
      issue(opfp(5'b11000, 5'd1, 5'd9, 5'd0), st, bb);
      chk("t4_cvt_stall", 32'(st), 32'd5);
      issue(flw(5'd10), st, bb);
      issue(fsw(5'd11, 5'd10), st, bb);
      chk("t4_fsw_rs1", 32'(st), 32'd0);
      idle(6);

      // 5: reset while stalled on f1 (counter at 3)
      issue(fadd1, st, bb);
      step(fsub1, 1'b1, acc);
      step(fsub1, 1'b1, acc);
      do_reset(1, fsub1, 1'b1);
      issue(fsub1, st, bb);
      chk("t5_stall", 32'(st), 32'd0);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/fpu_issue.md
Name: fpu_issue

Overview:
- Issue and interlock stage placed in front of the FPU datapath. It accepts FP instructions from the integer core over a valid/ready handshake and forwards them one per cycle on the FPU instruction bus.
- A per-register scoreboard models the FPU's fixed-latency float-register writeback pipeline. The block stalls any instruction that would read a float register whose write is still in flight.
- Bubbles are sent to the FPU as the all-zero instruction word, which decodes as no register write.

Parameters:
- PIPE_DEPTH, 5: cycles from an instruction appearing on fpu_inst to its float-register write becoming readable.
- NREG, 32: number of float registers. The index width is fixed at 5 bits.
- CNT_W, 3: scoreboard counter width. It must be wide enough to hold PIPE_DEPTH.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- in_inst  in  32  instruction from the core
- in_valid  in  1  in_inst is valid
- in_ready  out  1  block accepts in_inst this cycle
- fpu_inst  out  32  instruction to the FPU (registered); 32'h0 is a bubble
- fpu_busy  out  1  at least one scoreboard counter is nonzero
- stall_cnt  out  32  stall-cycle counter (FPU_ISSUE_STATS_EN only)
- issue_cnt  out  32  issued-instruction counter (FPU_ISSUE_STATS_EN only)

Behaviour:
- Reset is synchronous, sampled on the clk rising edge while rstn=0. It sets fpu_inst=0, clears every scoreboard counter to 0, drives fpu_busy=0 and clears the statistics counters.
- Reset mid-flight discards all pending-write tracking. No stall persists past reset.

Decode (combinational, on in_inst):
- FLW (opcode 0000111): writes rd.
- FSW (0100111): reads rs2.
- OP-FP (1010011), selected by funct5 = inst[31:27]:
  - 00000 fadd, 00001 fsub, 00010 fmul: read rs1 and rs2, write rd.
  - 11010 fcvt.s.w: writes rd, no float read.
  - 11000 fcvt.w.s: reads rs1, no float write.
- Any other opcode or funct5: no float read, no float write. The word is still issued unchanged.

Scoreboard:
- One CNT_W-bit counter per register, cnt[r]. A nonzero value means a write to r is pending.
- Each cycle every nonzero counter decrements by 1, saturating at 0.
- When an issued instruction writes rd, cnt[rd] is loaded with PIPE_DEPTH. The load takes priority over the decrement on the same register.

Hazard and handshake:
- hazard = (reads rs1 and cnt[rs1]!=0) or (reads rs2 and cnt[rs2]!=0).
- Counters are checked as they stand this cycle, before any same-edge update.
- in_ready = rstn & ~hazard. It is combinational and independent of in_valid.
- When in_valid & in_ready: fpu_inst <= in_inst on the next edge. Latency is 1 cycle.
- Otherwise: fpu_inst <= 32'h0.
- WAW is not stalled, because all writes retire in order at a fixed depth.
- Back-to-back dependent pair (e.g. fadd f1, then fmul f2,f1,f1): the second instruction is held for exactly PIPE_DEPTH cycles after the first issues.
- in_inst must stay stable while in_valid=1 and in_ready=0.
- fpu_busy is the OR of all counters, registered with the counters.

Optional Feature:
- Macro FPU_ISSUE_STATS_EN.
- When defined:
  - stall_cnt increments on each cycle with in_valid & ~in_ready.
  - issue_cnt increments on each accepted instruction.
  - Both are 32-bit, wrap modulo 2^32 and clear on reset.
- When undefined: both ports are driven constant 0 and no counter flops are synthesized.

Decomposition:
- Shared package fpu_pkg holds:
  - opcode constants: OPC_FLW, OPC_FSW, OPC_OPFP;
  - funct5 constants: F5_ADD, F5_SUB, F5_MUL, F5_CVT_WS, F5_CVT_SW;
  - the bubble constant FPU_NOP = 32'h0.
- One sub-module, fpu_issue_decode: combinational, in_inst -> reads_rs1, reads_rs2, writes_rd.
- The scoreboard and handshake stay in fpu_issue.

Test Plan:
1. Reset: hold rstn=0 for 2 cycles with in_valid=1 (fadd f3,f1,f2) -> fpu_inst=0, in_ready=0, fpu_busy=0. After release, the instruction issues on the first cycle.
2. Independent stream: fadd f1,f2,f3; fmul f4,f5,f6; flw f7 -> issued on 3 consecutive cycles, no stall cycles, fpu_busy=1 until 5 cycles after the last issue.
3. RAW on rs1: fadd f1,f2,f3 followed by fsub f4,f1,f5 -> in_ready=0 for exactly 5 cycles, then fsub issues. Exactly 5 bubbles (fpu_inst=0) appear between the two instructions.
4. RAW via store and convert: flw f8, then fsw f8 -> 5-cycle stall. fcvt.s.w f9 then fcvt.w.s x1,f9 -> 5-cycle stall. fsw with a busy rs1 only -> no stall.
5. Reset mid-stall: stall on f1 pending (cnt=3), assert rstn=0 for 1 cycle -> all counters 0; the next instruction reading f1 issues immediately.
6. FPU_ISSUE_STATS_EN defined: run scenario 3 -> issue_cnt=2, stall_cnt=5. Undefined -> both read 0.
